// File: rtl/si570_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : si570_cfg_sequencer_if
//  Description : Command (rv0) / read-response (rv1) channel pair between the
//                Si570 configuration sequencer and the i2c_master.
//  Signals     : rv0_valid/rv0_ready      command handshake
//                rv0_slave_address        7-bit I2C device address
//                rv0_reg_address          first register of the burst
//                rv0_burst_count          number of bytes minus one
//                rv0_rd_wrn               1 = read, 0 = write
//                rv0_wdata                byte k goes to reg_address+k
//                rv1_valid/rv1_ready      read-response handshake
//                rv1_rdata                read data, byte 0 in [7:0]
//  Modports    : master = sequencer side, slave = i2c_master side
//  Revision    : 1.0  initial release
// ============================================================================
interface si570_cfg_sequencer_if;
  logic        rv0_valid;
  logic        rv0_ready;
  logic [6:0]  rv0_slave_address;
  logic [7:0]  rv0_reg_address;
  logic [1:0]  rv0_burst_count;
  logic        rv0_rd_wrn;
  logic [31:0] rv0_wdata;
  logic        rv1_valid;
  logic        rv1_ready;
  logic [31:0] rv1_rdata;

  modport master (
    output rv0_valid, rv0_slave_address, rv0_reg_address, rv0_burst_count,
           rv0_rd_wrn, rv0_wdata, rv1_ready,
    input  rv0_ready, rv1_valid, rv1_rdata
  );

  modport slave (
    input  rv0_valid, rv0_slave_address, rv0_reg_address, rv0_burst_count,
           rv0_rd_wrn, rv0_wdata, rv1_ready,
    output rv0_ready, rv1_valid, rv1_rdata
  );
endinterface
`default_nettype wire

// File: rtl/si570_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : si570_cfg_sequencer
//  Description : Runs a complete Si570 output-frequency change through the
//                i2c_master: freeze DCO, write regs 7..12 (HS_DIV/N1/RFREQ),
//                unfreeze, set NewFreq, then poll reg 135 until NewFreq
//                clears. Lives in the i2c_clk domain.
//  Ports       : i_clk, i_rst_n         clock, synchronous active-low reset
//                i_cfg_valid/o_cfg_ready new-frequency request handshake
//                i_cfg_hs_div/n1/rfreq   Si570 divider and RFREQ codes
//                o_busy                  high whenever not idle
//                o_done                  one-cycle success pulse
//                o_error                 sticky timeout / poll-overflow flag
//                io_rv                   rv0 command / rv1 response channels
//  Revision    : 1.0  initial release
// ============================================================================
module si570_cfg_sequencer #(
  parameter logic [6:0]  SLAVE_ADDRESS  = 7'h5D,
  parameter logic [7:0]  POLL_MAX       = 8'd255,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst_n,
  input  wire logic        i_cfg_valid,
  output logic             o_cfg_ready,
  input  wire logic [2:0]  i_cfg_hs_div,
  input  wire logic [6:0]  i_cfg_n1,
  input  wire logic [37:0] i_cfg_rfreq,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  si570_cfg_sequencer_if.master io_rv
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FREEZE    = 4'd1,
    S_WR_A      = 4'd2,
    S_WR_B      = 4'd3,
    S_UNFREEZE  = 4'd4,
    S_NEWFREQ   = 4'd5,
    S_POLL_RD   = 4'd6,
    S_POLL_WAIT = 4'd7,
    S_DONE      = 4'd8,
    S_ERROR     = 4'd9
  } state_t;

  state_t      r_state;
  // Packed register image: R7 in [7:0] up to R12 in [47:40].
  logic [47:0] r_regs;
  logic        r_rv0_valid;
  logic [7:0]  r_rv0_reg;
  logic [1:0]  r_rv0_burst;
  logic        r_rv0_rd;
  logic [31:0] r_rv0_wdata;
  logic        r_rv1_ready;
  logic        r_done;
  logic        r_error;
  logic [15:0] r_wait_cnt;
  logic [7:0]  r_poll_cnt;

  state_t      w_state_nxt;
  logic [47:0] w_regs_nxt;
  logic        w_rv0_valid_nxt;
  logic [7:0]  w_rv0_reg_nxt;
  logic [1:0]  w_rv0_burst_nxt;
  logic        w_rv0_rd_nxt;
  logic [31:0] w_rv0_wdata_nxt;
  logic        w_error_nxt;
  logic [15:0] w_wait_nxt;
  logic [7:0]  w_poll_nxt;
  logic        w_rv0_hs;
  logic        w_rv1_hs;
  logic        w_cmd_state;
  logic        w_waiting;
  logic [15:0] w_wait_inc;
  logic [7:0]  w_poll_inc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_regs      <= '0;
      r_rv0_valid <= 1'b0;
      r_rv0_reg   <= '0;
      r_rv0_burst <= '0;
      r_rv0_rd    <= 1'b0;
      r_rv0_wdata <= '0;
      r_rv1_ready <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_wait_cnt  <= '0;
      r_poll_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_regs      <= w_regs_nxt;
      r_rv0_valid <= w_rv0_valid_nxt;
      r_rv0_reg   <= w_rv0_reg_nxt;
      r_rv0_burst <= w_rv0_burst_nxt;
      r_rv0_rd    <= w_rv0_rd_nxt;
      r_rv0_wdata <= w_rv0_wdata_nxt;
      r_rv1_ready <= (w_state_nxt == S_POLL_WAIT);
      r_done      <= (w_state_nxt == S_DONE);
      r_error     <= w_error_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_poll_cnt  <= w_poll_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_regs_nxt      = r_regs;
    w_error_nxt     = r_error;
    w_wait_nxt      = r_wait_cnt;
    w_poll_nxt      = r_poll_cnt;
    w_rv0_valid_nxt = 1'b0;
    w_rv0_reg_nxt   = 8'd0;
    w_rv0_burst_nxt = 2'd0;
    w_rv0_rd_nxt    = 1'b0;
    w_rv0_wdata_nxt = 32'd0;

    w_rv0_hs    = r_rv0_valid && io_rv.rv0_ready;
    w_rv1_hs    = r_rv1_ready && io_rv.rv1_valid;
    w_cmd_state = (r_state == S_FREEZE)   || (r_state == S_WR_A)    ||
                  (r_state == S_WR_B)     || (r_state == S_UNFREEZE) ||
                  (r_state == S_NEWFREQ)  || (r_state == S_POLL_RD);
    w_waiting   = w_cmd_state || (r_state == S_POLL_WAIT);
    w_wait_inc  = r_wait_cnt + 16'd1;
    w_poll_inc  = r_poll_cnt + 8'd1;

    case (r_state)
      S_IDLE: begin
        if (i_cfg_valid) begin
          w_regs_nxt  = {i_cfg_rfreq[7:0], i_cfg_rfreq[15:8],
                         i_cfg_rfreq[23:16], i_cfg_rfreq[31:24],
                         i_cfg_n1[1:0], i_cfg_rfreq[37:32],
                         i_cfg_hs_div, i_cfg_n1[6:2]};
          w_error_nxt = 1'b0;
          w_poll_nxt  = 8'd0;
          w_state_nxt = S_FREEZE;
        end
      end
      S_FREEZE:   if (w_rv0_hs) w_state_nxt = S_WR_A;
      S_WR_A:     if (w_rv0_hs) w_state_nxt = S_WR_B;
      S_WR_B:     if (w_rv0_hs) w_state_nxt = S_UNFREEZE;
      S_UNFREEZE: if (w_rv0_hs) w_state_nxt = S_NEWFREQ;
      S_NEWFREQ:  if (w_rv0_hs) w_state_nxt = S_POLL_RD;
      S_POLL_RD:  if (w_rv0_hs) w_state_nxt = S_POLL_WAIT;
      S_POLL_WAIT: begin
        if (w_rv1_hs) begin
          if (!io_rv.rv1_rdata[6]) begin
            w_state_nxt = S_DONE;
          end else if (w_poll_inc == POLL_MAX) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_poll_nxt  = w_poll_inc;
            w_state_nxt = S_POLL_RD;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERROR: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // A handshake that lands on the timeout cycle wins over the timeout.
    if (w_waiting && (w_state_nxt == r_state)) begin
      if (w_wait_inc == TIMEOUT_CYCLES) begin
        w_state_nxt = S_ERROR;
      end else begin
        w_wait_nxt = w_wait_inc;
      end
    end
    if (w_state_nxt != r_state) begin
      w_wait_nxt = 16'd0;
    end
    if (w_state_nxt == S_ERROR) begin
      w_error_nxt = 1'b1;
    end

    // Valid is low on the entry cycle of each command state and high for
    // every following cycle spent there, so it never depends on ready.
    w_rv0_valid_nxt = w_cmd_state && (w_state_nxt == r_state);

    // Payload tracks the state being entered, so it is already settled the
    // cycle before valid rises and stays constant while waiting.
    case (w_state_nxt)
      S_FREEZE: begin
        w_rv0_reg_nxt   = 8'd137;
        w_rv0_wdata_nxt = 32'h0000_0010;
      end
      S_WR_A: begin
        w_rv0_reg_nxt   = 8'd7;
        w_rv0_burst_nxt = 2'd3;
        w_rv0_wdata_nxt = w_regs_nxt[31:0];
      end
      S_WR_B: begin
        w_rv0_reg_nxt   = 8'd11;
        w_rv0_burst_nxt = 2'd1;
        w_rv0_wdata_nxt = {16'd0, w_regs_nxt[47:32]};
      end
      S_UNFREEZE: begin
        w_rv0_reg_nxt   = 8'd137;
      end
      S_NEWFREQ: begin
        w_rv0_reg_nxt   = 8'd135;
        w_rv0_wdata_nxt = 32'h0000_0040;
      end
      S_POLL_RD: begin
        w_rv0_reg_nxt   = 8'd135;
        w_rv0_rd_nxt    = 1'b1;
      end
      default: begin
        w_rv0_reg_nxt   = 8'd0;
      end
    endcase
  end

  assign o_cfg_ready             = (r_state == S_IDLE);
  assign o_busy                  = (r_state != S_IDLE);
  assign o_done                  = r_done;
  assign o_error                 = r_error;
  assign io_rv.rv0_valid         = r_rv0_valid;
  assign io_rv.rv0_slave_address = SLAVE_ADDRESS;
  assign io_rv.rv0_reg_address   = r_rv0_reg;
  assign io_rv.rv0_burst_count   = r_rv0_burst;
  assign io_rv.rv0_rd_wrn        = r_rv0_rd;
  assign io_rv.rv0_wdata         = r_rv0_wdata;
  assign io_rv.rv1_ready         = r_rv1_ready;

endmodule
`default_nettype wire

// File: tb/tb_si570_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_si570_cfg_sequencer
//  Description : Directed self-checking bench for si570_cfg_sequencer with a
//                command scoreboard and a NewFreq poll responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_si570_cfg_sequencer;
  localparam int TIMEOUT = 65535;
  localparam int PMAX    = 255;

  typedef struct packed {
    logic [7:0]  reg_a;
    logic [1:0]  burst;
    logic        rd;
    logic [31:0] wdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_hs_div;
  logic [6:0]  cfg_n1;
  logic [37:0] cfg_rfreq;
  logic        busy;
  logic        done;
  logic        error;

  si570_cfg_sequencer_if rv ();

  si570_cfg_sequencer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfg_valid  (cfg_valid),
    .o_cfg_ready  (cfg_ready),
    .i_cfg_hs_div (cfg_hs_div),
    .i_cfg_n1     (cfg_n1),
    .i_cfg_rfreq  (cfg_rfreq),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .io_rv        (rv)
  );

  always #5 clk = ~clk;

  cmd_t        exp_q[$];
  cmd_t        mon_exp;
  int          n_checks = 0;
  int          n_errors = 0;
  int          rd_cnt   = 0;
  int          done_cnt = 0;
  int          poll_busy_left = 0;
  bit          poll_always_busy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [7:0] r, input logic [1:0] b,
                              input logic rd, input logic [31:0] w);
    cmd_t c;
    c.reg_a = r; c.burst = b; c.rd = rd; c.wdata = w;
    return c;
  endfunction

  function automatic cmd_t cur_cmd();
    return mk(rv.rv0_reg_address, rv.rv0_burst_count, rv.rv0_rd_wrn, rv.rv0_wdata);
  endfunction

  // Expected command list for one frequency change ending in nreads polls.
  task automatic push_seq(input logic [2:0] hs, input logic [6:0] n1,
                          input logic [37:0] rf, input int nreads);
    logic [7:0] r7, r8;
    r7 = {hs, n1[6:2]};
    r8 = {n1[1:0], rf[37:32]};
    exp_q.push_back(mk(8'd137, 2'd0, 1'b0, 32'h10));
    exp_q.push_back(mk(8'd7,   2'd3, 1'b0, {rf[23:16], rf[31:24], r8, r7}));
    exp_q.push_back(mk(8'd11,  2'd1, 1'b0, {16'h0, rf[7:0], rf[15:8]}));
    exp_q.push_back(mk(8'd137, 2'd0, 1'b0, 32'h00));
    exp_q.push_back(mk(8'd135, 2'd0, 1'b0, 32'h40));
    for (int i = 0; i < nreads; i++) exp_q.push_back(mk(8'd135, 2'd0, 1'b1, 32'h0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [2:0] hs, input logic [6:0] n1, input logic [37:0] rf);
    cfg_hs_div = hs;
    cfg_n1     = n1;
    cfg_rfreq  = rf;
    cfg_valid  = 1'b1;
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  // Scoreboard pop on rv0 handshakes, poll responder, done-pulse counter.
  // Outside POLL_WAIT the response carries the busy bit, so a beat wrongly
  // consumed there would extend polling and show up in the read count.
  always @(negedge clk) begin
    if (rst_n && rv.rv0_valid && rv.rv0_ready) begin
      if (rv.rv0_rd_wrn) rd_cnt++;
      chk("rv0_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        chk("rv0_cmd", cur_cmd(), mon_exp);
        chk("rv0_slave", rv.rv0_slave_address, 7'h5D);
      end
    end
    if (rv.rv1_ready) begin
      rv.rv1_rdata = (poll_always_busy || poll_busy_left > 0) ? 32'h40 : 32'h0;
      if (poll_busy_left > 0) poll_busy_left--;
    end else begin
      rv.rv1_rdata = 32'hFFFF_FFFF;
    end
    if (done) done_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n, d0, r0;
    logic [31:0] wra, wrb;

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_hs_div = '0; cfg_n1 = '0; cfg_rfreq = '0;
    rv.rv0_ready = 1'b0; rv.rv1_valid = 1'b1; rv.rv1_rdata = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_rv0_valid", rv.rv0_valid, 1'b0);
    chk("rst_rv1_ready", rv.rv1_ready, 1'b0);
    chk("rst_payload", cur_cmd(), '0);
    rst_n = 1'b1;
    tick();

    // Nominal run, ready tied high, immediate idle poll; latency and packing
    rv.rv0_ready = 1'b1; poll_busy_left = 0;
    d0 = done_cnt; r0 = rd_cnt; wra = '0; wrb = '0;
    push_seq(3'd1, 7'd7, 38'h2BC0123456, 1);
    send_cfg(3'd1, 7'd7, 38'h2BC0123456);
    chk("accept_busy", busy, 1'b1);
    chk("lat_valid0", rv.rv0_valid, 1'b0);
    tick();
    chk("lat_valid1", rv.rv0_valid, 1'b1);
    n = 1;
    while (!done && n < 100) begin
      if (rv.rv0_valid && rv.rv0_reg_address == 8'd7)  wra = rv.rv0_wdata;
      if (rv.rv0_valid && rv.rv0_reg_address == 8'd11) wrb = rv.rv0_wdata;
      tick();
      n++;
    end
    chk("min_latency", n, 13);
    chk("wr_a_wdata", wra, 32'h12C0_EB21);
    chk("wr_b_wdata", wrb, 32'h0000_5634);
    tick();
    chk("done_single", done, 1'b0);
    chk("nom_error", error, 1'b0);
    chk("nom_idle", cfg_ready, 1'b1);
    chk("nom_done_cnt", done_cnt - d0, 1);
    chk("nom_reads", rd_cnt - r0, 1);
    chk("nom_q_empty", exp_q.size(), 0);

    // Stall in FREEZE for 10 cycles, then 3 busy polls
    rv.rv0_ready = 1'b0; poll_busy_left = 3;
    d0 = done_cnt; r0 = rd_cnt;
    push_seq(3'd5, 7'h55, 38'h3FDEADBEEF, 4);
    send_cfg(3'd5, 7'h55, 38'h3FDEADBEEF);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", rv.rv0_valid, 1'b1);
      chk("stall_payload", cur_cmd(), mk(8'd137, 2'd0, 1'b0, 32'h10));
      tick();
    end
    rv.rv0_ready = 1'b1;
    tick();
    chk("stall_adv_valid", rv.rv0_valid, 1'b0);
    chk("stall_adv_reg", rv.rv0_reg_address, 8'd7);
    wait_idle("stall_idle", 200);
    chk("poll4_reads", rd_cnt - r0, 4);
    chk("poll4_done", done_cnt - d0, 1);
    chk("poll4_error", error, 1'b0);
    chk("poll4_q_empty", exp_q.size(), 0);

    // NewFreq never clears: poll overflow
    poll_always_busy = 1'b1;
    d0 = done_cnt; r0 = rd_cnt;
    push_seq(3'd2, 7'd3, 38'h01_0000_0001, PMAX);
    send_cfg(3'd2, 7'd3, 38'h01_0000_0001);
    wait_idle("povf_idle", 5000);
    chk("povf_error", error, 1'b1);
    chk("povf_reads", rd_cnt - r0, PMAX);
    chk("povf_no_done", done_cnt - d0, 0);
    chk("povf_q_empty", exp_q.size(), 0);

    // Next accepted cfg clears the sticky error
    poll_always_busy = 1'b0; poll_busy_left = 0;
    d0 = done_cnt;
    push_seq(3'd0, 7'd1, 38'h0, 1);
    send_cfg(3'd0, 7'd1, 38'h0);
    chk("err_cleared", error, 1'b0);
    wait_idle("clr_idle", 100);
    chk("clr_done", done_cnt - d0, 1);

    // rv0 never ready: handshake timeout; cfg while busy ignored
    rv.rv0_ready = 1'b0;
    d0 = done_cnt;
    send_cfg(3'd4, 7'd9, 38'h12_3456_789A);
    cfg_hs_div = 3'd7; cfg_n1 = 7'h7F; cfg_rfreq = '1; cfg_valid = 1'b1;
    n = 0;
    repeat (5) begin
      tick();
      n++;
    end
    chk("busy_cfg_ready", cfg_ready, 1'b0);
    chk("busy_payload", cur_cmd(), mk(8'd137, 2'd0, 1'b0, 32'h10));
    cfg_valid = 1'b0;
    while (!error && n < TIMEOUT + 100) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, TIMEOUT);
    chk("timeout_valid", rv.rv0_valid, 1'b0);
    tick();
    chk("timeout_idle", busy, 1'b0);
    chk("timeout_sticky", error, 1'b1);
    chk("timeout_no_done", done_cnt - d0, 0);

    // Reset in the middle of WR_A with valid high
    rv.rv0_ready = 1'b1;
    push_seq(3'd1, 7'd2, 38'h5, 1);
    send_cfg(3'd1, 7'd2, 38'h5);
    n = 0;
    while (!(rv.rv0_valid && rv.rv0_reg_address == 8'd7) && n < 20) begin
      tick();
      n++;
    end
    chk("mid_in_wr_a", rv.rv0_valid, 1'b1);
    rst_n = 1'b0;
    rv.rv0_ready = 1'b0;
    tick();
    chk("mid_rst_valid", rv.rv0_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cfg_ready", cfg_ready, 1'b1);
    chk("mid_rst_payload", cur_cmd(), '0);
    rst_n = 1'b1;
    exp_q.delete();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
